uart_packet_receiver: RTL

//   Framing front-end between the UartRx byte deserializer and the CoRAM word loader.

---
 rtl/uart_packet_receiver.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_packet_receiver.sv
// -----------------------------------------------------------------------------
// uart_packet_receiver
//   Framing front-end between a UART byte deserializer and a word loader.
//   Hunts for a sync byte, reads a length byte (in words), packs the payload
//   little-endian into W_D-bit words, and buffers them in a word FIFO with a
//   valid/ready output. A trailing checksum byte is verified and each packet
//   ends with a one-cycle PKT_DONE or PKT_ERR pulse.
//
//   Frame: SYNC, LEN (1..255 words), LEN*BPW payload bytes, CSUM
//          CSUM = (LEN + sum of payload bytes) mod 256
//
//   Optional feature: define UART_PKT_TIMEOUT_EN to abort a frame after
//   TIMEOUT_CYCLES idle cycles between bytes (ERR_CODE 11).
//
// Ports
//   clk_i         system clock
//   rst_n_i       asynchronous active-low reset
//   rx_data_i     received byte, qualified by rx_en_i
//   rx_en_i       one-cycle byte strobe (no backpressure)
//   out_data_o    FIFO head word (0 when empty)
//   out_last_o    head word is the last word of its packet
//   out_valid_o   FIFO non-empty
//   out_ready_i   consumer pops head when out_valid_o && out_ready_i
//   pkt_done_o    pulse: frame complete, checksum matched
//   pkt_err_o     pulse: frame aborted or checksum mismatch
//   err_code_o    with pkt_err_o: 01 checksum, 10 zero length, 11 timeout
//   ovf_o         sticky: a completed word was dropped on a full FIFO
//   busy_o        FSM is not hunting for sync
//
// States
//   state     | meaning
//   ----------+---------------------------------------------
//   ST_HUNT   | waiting for SYNC_BYTE, other bytes ignored
//   ST_LENGTH | next byte is the word count
//   ST_DATA   | collecting payload bytes into words
//   ST_CSUM   | next byte is the checksum
// -----------------------------------------------------------------------------
module uart_packet_receiver #(
  parameter int         W_D            = 32,
  parameter int         W_FIFO_A       = 4,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic [7:0]     rx_data_i,
  input  logic           rx_en_i,
  output logic [W_D-1:0] out_data_o,
  output logic           out_last_o,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic           pkt_done_o,
  output logic           pkt_err_o,
  output logic [1:0]     err_code_o,
  output logic           ovf_o,
  output logic           busy_o
);

  localparam int BPW   = W_D / 8;
  localparam int DEPTH = 2 ** W_FIFO_A;
  localparam int BCW   = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BCW-1:0]    BYTE_LAST = BCW'(BPW - 1);
  localparam logic [W_FIFO_A:0] CNT_FULL  = (W_FIFO_A + 1)'(DEPTH);

  if ((W_D % 8) != 0 || W_D < 8) begin : g_bad_w_d
    $error("W_D must be a non-zero multiple of 8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_LENGTH = 2'd1,
    ST_DATA   = 2'd2,
    ST_CSUM   = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [7:0]     len_q, len_d;
  logic [7:0]     word_cnt_q, word_cnt_d;
  logic [7:0]     sum_q, sum_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic [W_D-1:0] shift_q, shift_d, shift_nxt;
  logic           push_q, push_d;
  logic [W_D-1:0] push_data_q, push_data_d;
  logic           push_last_q, push_last_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [1:0]     code_q, code_d;
  logic [8:0]     word_cnt_inc;
  logic           word_last;
  logic           timeout_fire;

  // New byte enters at the top, so after BPW bytes the first one sits in [7:0].
  if (W_D > 8) begin : g_shift_wide
    assign shift_nxt = {rx_data_i, shift_q[W_D-1:8]};
  end else begin : g_shift_byte
    assign shift_nxt = rx_data_i;
  end

  assign word_cnt_inc = {1'b0, word_cnt_q} + 9'd1;
  assign word_last    = (word_cnt_inc == {1'b0, len_q});

`ifdef UART_PKT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] IDLE_LOAD = TW'(TIMEOUT_CYCLES - 1);

  // Down-counter reloaded on every byte; terminal count with no byte this
  // cycle means TIMEOUT_CYCLES idle cycles have elapsed inside a frame.
  logic [TW-1:0] idle_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idle_q <= IDLE_LOAD;
    end else if (rx_en_i || state_q == ST_HUNT) begin
      idle_q <= IDLE_LOAD;
    end else if (idle_q != '0) begin
      idle_q <= idle_q - TW'(1);
    end
  end

  assign timeout_fire = (state_q != ST_HUNT) && !rx_en_i && (idle_q == '0);
`else
  assign timeout_fire = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_HUNT;
      len_q       <= '0;
      word_cnt_q  <= '0;
      sum_q       <= '0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      push_last_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      sum_q       <= sum_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      push_last_q <= push_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
      code_q      <= code_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    sum_d       = sum_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    push_last_d = push_last_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    code_d      = code_q;

    if (timeout_fire) begin
      // Partial word is discarded; words already queued stay queued.
      state_d    = ST_HUNT;
      err_d      = 1'b1;
      code_d     = 2'b11;
      byte_cnt_d = '0;
      word_cnt_d = '0;
      shift_d    = '0;
    end else if (rx_en_i) begin
      unique case (state_q)
        ST_HUNT: begin
          if (rx_data_i == SYNC_BYTE) state_d = ST_LENGTH;
        end
        ST_LENGTH: begin
          if (rx_data_i == 8'h00) begin
            err_d   = 1'b1;
            code_d  = 2'b10;
            state_d = ST_HUNT;
          end else begin
            len_d      = rx_data_i;
            sum_d      = rx_data_i;
            word_cnt_d = '0;
            byte_cnt_d = '0;
            shift_d    = '0;
            state_d    = ST_DATA;
          end
        end
        ST_DATA: begin
          sum_d   = sum_q + rx_data_i;
          shift_d = shift_nxt;
          if (byte_cnt_q == BYTE_LAST) begin
            byte_cnt_d  = '0;
            word_cnt_d  = word_cnt_inc[7:0];
            push_d      = 1'b1;
            push_data_d = shift_nxt;
            push_last_d = word_last;
            if (word_last) state_d = ST_CSUM;
          end else begin
            byte_cnt_d = byte_cnt_q + BCW'(1);
          end
        end
        ST_CSUM: begin
          if (rx_data_i == sum_q) begin
            done_d = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = 2'b01;
          end
          state_d = ST_HUNT;
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // Word FIFO: registered occupancy count 0..DEPTH, pointers wrap naturally.
  logic [W_D:0]        mem_q [DEPTH];
  logic [W_FIFO_A-1:0] wr_ptr_q, rd_ptr_q;
  logic [W_FIFO_A:0]   count_q;
  logic                ovf_q;
  logic                pop, push_ok;

  assign out_valid_o = (count_q != '0);
  assign pop         = out_valid_o && out_ready_i;
  // A full FIFO still takes the word when the head leaves in the same cycle.
  assign push_ok     = push_q && ((count_q != CNT_FULL) || pop);

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= {push_last_q, push_data_q};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + W_FIFO_A'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + W_FIFO_A'(1);
      if (push_ok && !pop)      count_q <= count_q + (W_FIFO_A + 1)'(1);
      else if (!push_ok && pop) count_q <= count_q - (W_FIFO_A + 1)'(1);
      if (push_q && !push_ok)   ovf_q <= 1'b1;
    end
  end

  // Memory is not reset, so the head is masked while the FIFO is empty.
  assign out_data_o = out_valid_o ? mem_q[rd_ptr_q][W_D-1:0] : '0;
  assign out_last_o = out_valid_o ? mem_q[rd_ptr_q][W_D]     : 1'b0;
  assign pkt_done_o = done_q;
  assign pkt_err_o  = err_q;
  assign err_code_o = code_q;
  assign ovf_o      = ovf_q;
  assign busy_o     = (state_q != ST_HUNT);

endmodule
